// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared FSM states, widths and timing defaults for the memory request controller
package mem_pkg;

  // Default memory geometry
  localparam int AW_DEF = 12;
  localparam int DW_DEF = 8;

  // Default timing, all in clk cycles
  localparam int WAKE_CYC_DEF = 2;
  localparam int ACC_CYC_DEF  = 2;
  localparam int RD_LAT_DEF   = 1;
  localparam int IDLE_TO_DEF  = 4;

  // Width of the single down-counter shared by every timed phase
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    ST_SLEEP,
    ST_WAKE,
    ST_IDLE,
    ST_ACCESS,
    ST_RDWAIT,
    ST_RESP
  } state_t;

  // A phase lasting n cycles starts the down-counter at n-1 and ends when it reads zero
  function automatic logic [CNT_W-1:0] cnt_load(input int n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/mem_req_ctrl.sv
// rtl/mem_req_ctrl.sv - single-outstanding request controller for a sleepable SRAM-style memory
module mem_req_ctrl
  import mem_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int WAKE_CYC = WAKE_CYC_DEF,
  parameter int ACC_CYC  = ACC_CYC_DEF,
  parameter int RD_LAT   = RD_LAT_DEF,
  parameter int IDLE_TO  = IDLE_TO_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          mem_cen,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_add,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_wr;
  logic             r_req_ready;
  logic             r_rsp_valid;
  logic [DW-1:0]    r_rsp_rdata;
  logic             r_mem_cen;
  logic             r_mem_rd;
  logic             r_mem_wr;
  logic [AW-1:0]    r_mem_add;
  logic [DW-1:0]    r_mem_din;

  logic             w_xfer;
  logic             w_cnt_done;

  assign w_xfer     = req_valid & r_req_ready;
  assign w_cnt_done = (r_cnt == '0);

  // Sequencer: every output is a register updated alongside the state it belongs to
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_SLEEP;
      r_cnt       <= '0;
      r_wr        <= 1'b0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_mem_cen   <= 1'b1;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_add   <= '0;
      r_mem_din   <= '0;
    end else begin
      case (r_state)
        ST_SLEEP: begin
          if (w_xfer) begin
            r_mem_add   <= req_addr;
            r_mem_din   <= req_wr ? req_wdata : '0;
            r_wr        <= req_wr;
            r_req_ready <= 1'b0;
            r_mem_cen   <= 1'b0;
            r_cnt       <= cnt_load(WAKE_CYC);
            r_state     <= ST_WAKE;
          end
        end

        ST_WAKE: begin
          if (w_cnt_done) begin
            r_mem_rd <= ~r_wr;
            r_mem_wr <= r_wr;
            r_cnt    <= cnt_load(ACC_CYC);
            r_state  <= ST_ACCESS;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        ST_IDLE: begin
          if (w_xfer) begin
            // Memory is already awake, so the strobe goes out on the very next cycle
            r_mem_add   <= req_addr;
            r_mem_din   <= req_wr ? req_wdata : '0;
            r_wr        <= req_wr;
            r_req_ready <= 1'b0;
            r_mem_rd    <= ~req_wr;
            r_mem_wr    <= req_wr;
            r_cnt       <= cnt_load(ACC_CYC);
            r_state     <= ST_ACCESS;
          end else if (w_cnt_done) begin
            r_mem_cen <= 1'b1;
            r_state   <= ST_SLEEP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        ST_ACCESS: begin
          if (w_cnt_done) begin
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            if (r_wr) begin
              r_rsp_rdata <= '0;
              r_rsp_valid <= 1'b1;
              r_state     <= ST_RESP;
            end else begin
              r_cnt   <= cnt_load(RD_LAT);
              r_state <= ST_RDWAIT;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        ST_RDWAIT: begin
          if (w_cnt_done) begin
            r_rsp_rdata <= mem_dout;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_cnt       <= cnt_load(IDLE_TO);
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_mem_cen   <= 1'b1;
          r_mem_rd    <= 1'b0;
          r_mem_wr    <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= ST_SLEEP;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign mem_cen   = r_mem_cen;
  assign mem_rd    = r_mem_rd;
  assign mem_wr    = r_mem_wr;
  assign mem_add   = r_mem_add;
  assign mem_din   = r_mem_din;

endmodule
